// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants, scan state type and hex-to-segment decode for the
// seven-segment scan driver.
package sevseg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam logic [7:0] ANODES_OFF = 8'hFF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Cathode pattern {a,b,c,d,e,f,g}, active-low
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display-word input and board-side outputs of the seven-segment scan driver.
interface sevenseg_scan_driver_if;
    logic [31:0] value_in;
    logic        load;
    logic        freeze;
    logic [2:0]  brightness;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        dp_n;
    logic [2:0]  digit_idx;
    logic        frame_done;

    modport master (
        output value_in, load, freeze, brightness, dp_mask,
        input  an, sev_out, dp_n, digit_idx, frame_done
    );

    modport slave (
        input  value_in, load, freeze, brightness, dp_mask,
        output an, sev_out, dp_n, digit_idx, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_driver_decoder.sv
// Nibble to active-low seven-segment cathode decoder.
module sevseg_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/sevenseg_scan_driver.sv
// Tear-free 8-digit multiplexed scanner with blank interval and PWM brightness.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module sevenseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk_7seg,
    input  logic                    Rst,
    sevenseg_scan_driver_if.slave   bus
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    scan_state_t   state_reg;
    logic [DW-1:0] dwell_cnt_reg;
    logic [BW-1:0] blank_cnt_reg;
    logic [2:0]    digit_idx_reg;
    logic [31:0]   pending_reg;
    logic [31:0]   shown_reg;
    logic [7:0]    an_reg;
    logic [6:0]    sev_out_reg;
    logic          dp_n_reg;
    logic          frame_done_reg;

    logic [3:0]          nibble_arr [NUM_DIGITS];
    logic [3:0]          cur_nibble;
    logic [6:0]          seg_dec;
    logic [DW-1:0]       dwell_inc;
    logic [7:0]          an_lit;
    logic                lz_dark;
    logic                lit_first;
    logic                lit_next;
    logic                capture;
    logic                frame_end;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nibble_arr[gi] = shown_reg[4*gi +: 4];
        end
    endgenerate

`ifdef SEVSEG_LZ_BLANK_EN
    // A digit goes dark when it and every digit above it are zero; digit 0 always shows
    logic [NUM_DIGITS-1:0] dark_mask;
    assign dark_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign dark_mask[gi] = (shown_reg[31:4*gi] == '0);
        end
    endgenerate
    assign lz_dark = dark_mask[digit_idx_reg];
`else
    assign lz_dark = 1'b0;
`endif

    assign cur_nibble = nibble_arr[digit_idx_reg];

    sevseg_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (seg_dec)
    );

    assign dwell_inc = dwell_cnt_reg + DW'(1);
    assign an_lit    = ~(8'b1 << digit_idx_reg);
    // Dwell count 0 is always within the duty window, so only blanking can darken it
    assign lit_first = !lz_dark;
    assign lit_next  = (dwell_inc[2:0] <= bus.brightness) && !lz_dark;
    assign capture   = bus.load && !bus.freeze;
    assign frame_end = (state_reg == ON) && (dwell_cnt_reg == DWELL_LAST) &&
                       (digit_idx_reg == LAST_DIGIT);

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            state_reg      <= BLANK;
            dwell_cnt_reg  <= '0;
            blank_cnt_reg  <= '0;
            digit_idx_reg  <= '0;
            pending_reg    <= '0;
            shown_reg      <= '0;
            an_reg         <= ANODES_OFF;
            sev_out_reg    <= SEG_OFF;
            dp_n_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            if (capture)
                pending_reg <= bus.value_in;
            // Shown only changes on the edge into digit 0's blank, so a frame never tears
            if (frame_end)
                shown_reg <= capture ? bus.value_in : pending_reg;

            case (state_reg)
                BLANK: begin
                    if (blank_cnt_reg == BLANK_LAST) begin
                        state_reg     <= ON;
                        dwell_cnt_reg <= '0;
                        an_reg        <= lit_first ? an_lit : ANODES_OFF;
                        sev_out_reg   <= seg_dec;
                        dp_n_reg      <= ~bus.dp_mask[digit_idx_reg];
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + BW'(1);
                    end
                end
                ON: begin
                    if (dwell_cnt_reg == DWELL_LAST) begin
                        state_reg      <= BLANK;
                        blank_cnt_reg  <= '0;
                        digit_idx_reg  <= digit_idx_reg + 3'd1;
                        an_reg         <= ANODES_OFF;
                        sev_out_reg    <= SEG_OFF;
                        dp_n_reg       <= 1'b1;
                        frame_done_reg <= (digit_idx_reg == LAST_DIGIT);
                    end else begin
                        dwell_cnt_reg <= dwell_inc;
                        an_reg        <= lit_next ? an_lit : ANODES_OFF;
                    end
                end
                default: state_reg <= BLANK;
            endcase
        end
    end

    assign bus.an         = an_reg;
    assign bus.sev_out    = sev_out_reg;
    assign bus.dp_n       = dp_n_reg;
    assign bus.digit_idx  = digit_idx_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
